// File: rtl/task_pkg.sv
// Shared definitions for the task blocks and the task sorter: opcodes,
// op-word and sorter-byte field positions, and the sorter state encoding.
package task_pkg;

   localparam logic [3:0] OP_READY   = 4'b0001;
   localparam logic [3:0] OP_SUSPEND = 4'b0010;
   localparam logic [3:0] OP_WAIT    = 4'b0011;
   localparam logic [3:0] OP_KILL    = 4'b0100;
   localparam logic [3:0] OP_PRIO    = 4'b0101;
   localparam logic [3:0] OP_HIT     = 4'b0110;
   localparam logic [3:0] OP_EXEC    = 4'b0111;
   localparam logic [3:0] OP_FINISH  = 4'b1111;

   // op word: {4'b0000, id, opcode, arg}
   localparam int OP_ID_LSB   = 8;
   localparam int OP_CODE_LSB = 4;
   localparam int OP_ARG_LSB  = 0;

   // sorter byte: {id, priority}; 8'h00 means not ready
   localparam int SB_ID_LSB   = 4;
   localparam int SB_PRIO_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DISPATCH,
      ST_SLICE,
      ST_FINISH
   } sorter_state_t;

   function automatic logic [15:0] make_op(input logic [3:0] id, input logic [3:0] code);
      logic [15:0] op;
      op = 16'h0000;
      op[OP_ID_LSB +: 4]   = id;
      op[OP_CODE_LSB +: 4] = code;
      op[OP_ARG_LSB +: 4]  = 4'h0;
      return op;
   endfunction

   function automatic logic [3:0] sb_id(input logic [7:0] b);
      return b[SB_ID_LSB +: 4];
   endfunction

   function automatic logic [3:0] sb_prio(input logic [7:0] b);
      return b[SB_PRIO_LSB +: 4];
   endfunction

endpackage

// File: rtl/task_sorter_cmp.sv
// Candidate-versus-best compare for the sorter scan; strict priority compare
// so the earliest index wins ties, and empty (8'h00) candidates never win.
module task_sorter_cmp
   import task_pkg::*;
(
   input  logic [7:0] cand,
   input  logic [7:0] best,
   output logic       take
);

   always_comb begin
      take = (cand != 8'h00) &&
             ((best == 8'h00) || (sb_prio(cand) > sb_prio(best)));
   end

endmodule

// File: rtl/task_sorter.sv
// Task scheduler: snapshots the ready bytes, scans them for the highest
// priority, issues Execute/Finish around a fixed quantum, forwards host ops.
//
// state       | meaning
// ST_IDLE     | snapshot in_tasks each cycle, accept host ops
// ST_SCAN     | walk snapshot one entry per cycle keeping the best
// ST_DISPATCH | issue Execute to the winner, clear quantum counter
// ST_SLICE    | count the quantum, accept host ops except on the last count
// ST_FINISH   | issue Finish to the running task
module task_sorter
   import task_pkg::*;
#(
   parameter int N_TASKS = 8,
   parameter int QUANTUM = 1000,
   parameter int CNT_W   = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [8*N_TASKS-1:0] in_tasks,
   input  logic [15:0]          host_op,
   input  logic                 host_valid,
   output logic                 host_ready,
   output logic [15:0]          out_op,
   output logic [3:0]           out_current,
   output logic                 busy
);

   localparam logic [3:0]       IDX_LAST = 4'(N_TASKS - 1);
   localparam logic [CNT_W-1:0] Q_LAST   = CNT_W'(QUANTUM - 1);

   sorter_state_t        state, state_nxt;
   logic [8*N_TASKS-1:0] snap, snap_nxt;
   logic [3:0]           idx, idx_nxt;
   logic [7:0]           best, best_nxt, best_sel, cand;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [15:0]          op_nxt;
   logic [3:0]           cur_nxt;
   logic                 ready_nxt, busy_nxt, take, xfer;

   always_comb begin
      cand = 8'h00;
      for (int i = 0; i < N_TASKS; i++) begin
         if (idx == 4'(i)) cand = snap[8*i +: 8];
      end
   end

   task_sorter_cmp u_cmp (
      .cand (cand),
      .best (best),
      .take (take)
   );

   assign best_sel = take ? cand : best;
   assign xfer     = host_valid && host_ready;

   always_comb begin
      state_nxt = state;
      snap_nxt  = snap;
      idx_nxt   = idx;
      best_nxt  = best;
      cnt_nxt   = cnt;
      op_nxt    = 16'h0000;
      cur_nxt   = out_current;
      case (state)
         ST_IDLE: begin
            snap_nxt = in_tasks;
            idx_nxt  = 4'd0;
            best_nxt = 8'h00;
            if (xfer) op_nxt = host_op;
            if (|in_tasks) state_nxt = ST_SCAN;
         end
         ST_SCAN: begin
            best_nxt = best_sel;
            idx_nxt  = idx + 4'd1;
            if (idx == IDX_LAST) state_nxt = (best_sel != 8'h00) ? ST_DISPATCH : ST_IDLE;
         end
         ST_DISPATCH: begin
            op_nxt    = make_op(sb_id(best), OP_EXEC);
            cur_nxt   = sb_id(best);
            cnt_nxt   = '0;
            state_nxt = ST_SLICE;
         end
         ST_SLICE: begin
            cnt_nxt = cnt + 1'b1;
            if (xfer) op_nxt = host_op;
            if (cnt == Q_LAST) state_nxt = ST_FINISH;
         end
         ST_FINISH: begin
            op_nxt    = make_op(out_current, OP_FINISH);
            cur_nxt   = 4'h0;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // host is held off on the last quantum count so Finish owns the bus
      ready_nxt = (state_nxt == ST_IDLE) ||
                  ((state_nxt == ST_SLICE) && (cnt_nxt != Q_LAST));
      busy_nxt  = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state       <= ST_IDLE;
         snap        <= '0;
         idx         <= 4'd0;
         best        <= 8'h00;
         cnt         <= '0;
         out_op      <= 16'h0000;
         out_current <= 4'h0;
         host_ready  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         snap        <= snap_nxt;
         idx         <= idx_nxt;
         best        <= best_nxt;
         cnt         <= cnt_nxt;
         out_op      <= op_nxt;
         out_current <= cur_nxt;
         host_ready  <= ready_nxt;
         busy        <= busy_nxt;
      end
   end

endmodule
